// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer driving a 1-bit-per-cycle shifter for AMT cycles.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             DIR,
    input  logic [AMT_W-1:0] AMT,
    input  logic             ROT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [WIDTH-1:0] SH_OUT,
    output logic [WIDTH-1:0] SH_IN,
    output logic             L_SHIFT,
    output logic             R_SHIFT,
    output logic             NO_SHIFT,
    output logic             LEFT_NOT,
    output logic             RIGHT_NOT,
    output logic             OLD_NOT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh_n;
    logic [AMT_W-1:0] count, count_n;
    logic             dir_q, dir_n;
    logic             armed;
    logic             l_n, r_n, no_n, busy_n, done_n;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot_q, rot_n;
`else
    logic             unused_rot;
    assign unused_rot = ROT;
`endif

    // armed blocks a START coinciding with the first edge after reset release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            SH_IN    <= '0;
            count    <= '0;
            dir_q    <= 1'b0;
            armed    <= 1'b0;
            L_SHIFT  <= 1'b0;
            R_SHIFT  <= 1'b0;
            NO_SHIFT <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            SH_IN    <= sh_n;
            count    <= count_n;
            dir_q    <= dir_n;
            armed    <= 1'b1;
            L_SHIFT  <= l_n;
            R_SHIFT  <= r_n;
            NO_SHIFT <= no_n;
            BUSY     <= busy_n;
            DONE     <= done_n;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q    <= rot_n;
`endif
        end
    end

    // Selects/BUSY/DONE are computed for the next state so they leave the flops glitch-free
    always_comb begin
        state_n = state;
        sh_n    = SH_IN;
        count_n = count;
        dir_n   = dir_q;
        l_n     = 1'b0;
        r_n     = 1'b0;
        no_n    = 1'b1;
        busy_n  = 1'b0;
        done_n  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_n   = rot_q;
`endif
        case (state)
            IDLE, DONE_ST: begin
                state_n = IDLE;
                if (START && armed) begin
                    sh_n    = DATA_IN;
                    count_n = AMT;
                    dir_n   = DIR;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_n   = ROT;
`endif
                    if (AMT != '0) begin
                        state_n = SHIFT;
                        l_n     = DIR;
                        r_n     = ~DIR;
                        no_n    = 1'b0;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = DONE_ST;
                        done_n  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                sh_n = SH_OUT;
`ifdef SHIFT_SEQ_ROTATE_EN
                if (rot_q) begin
                    if (dir_q)
                        sh_n = SH_OUT | {{(WIDTH-1){1'b0}}, SH_IN[WIDTH-1]};
                    else
                        sh_n = SH_OUT | {SH_IN[0], {(WIDTH-1){1'b0}}};
                end
`endif
                count_n = count - 1'b1;
                if (count == AMT_W'(1)) begin
                    state_n = DONE_ST;
                    done_n  = 1'b1;
                end else begin
                    l_n    = dir_q;
                    r_n    = ~dir_q;
                    no_n   = 1'b0;
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign LEFT_NOT  = ~L_SHIFT;
    assign RIGHT_NOT = ~R_SHIFT;
    assign OLD_NOT   = ~NO_SHIFT;
    assign RESULT    = SH_IN;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: behavioural shifter + transaction model checked every cycle,
// plus directed operations with literal expectations (honours SHIFT_SEQ_ROTATE_EN).
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [4:0]  amt = '0;
    logic        rot = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] sh_out;
    logic [31:0] sh_in, result;
    logic        l_shift, r_shift, no_shift, left_not, right_not, old_not, busy, done;

    int checks = 0;
    int failures = 0;

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .DIR(dir), .AMT(amt), .ROT(rot),
        .DATA_IN(data_in), .SH_OUT(sh_out), .SH_IN(sh_in),
        .L_SHIFT(l_shift), .R_SHIFT(r_shift), .NO_SHIFT(no_shift),
        .LEFT_NOT(left_not), .RIGHT_NOT(right_not), .OLD_NOT(old_not),
        .BUSY(busy), .DONE(done), .RESULT(result)
    );

    always #5 clk = ~clk;

    // 1-bit zero-fill shifter datapath
    assign sh_out = l_shift ? (sh_in << 1) : (r_shift ? (sh_in >> 1) : sh_in);

    function automatic logic [31:0] shifted(logic [31:0] d, int k, logic dr, logic r);
        if (k == 0) return d;
        if (r && ROT_EN) return dr ? ((d << k) | (d >> (32 - k))) : ((d >> k) | (d << (32 - k)));
        return dr ? (d << k) : (d >> k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: last accepted op, its start-of-shift cycle and amount
    int          cyc = 0;
    bit          have = 1'b0;
    bit          armed_m = 1'b0;
    int          mbs = 0;
    int          mamt = 0;
    logic [31:0] md = '0;
    logic        mdir = 1'b0;
    logic        mrot = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     <= 0;
            have    <= 1'b0;
            armed_m <= 1'b0;
        end else begin
            if (start && armed_m && !(have && cyc >= mbs && cyc < mbs + mamt)) begin
                have <= 1'b1;
                mbs  <= cyc + 1;
                mamt <= int'(amt);
                md   <= data_in;
                mdir <= dir;
                mrot <= rot;
            end
            armed_m <= 1'b1;
            cyc     <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int          k;
            logic        eb, ed;
            logic [31:0] es;
            eb = have && cyc >= mbs && cyc < mbs + mamt;
            ed = have && cyc == mbs + mamt;
            k  = cyc - mbs;
            if (k > mamt) k = mamt;
            es = have ? shifted(md, k, mdir, mrot) : 32'h0;
            chk("busy", {31'b0, busy}, {31'b0, eb});
            chk("done", {31'b0, done}, {31'b0, ed});
            chk("l_shift", {31'b0, l_shift}, {31'b0, eb && mdir});
            chk("r_shift", {31'b0, r_shift}, {31'b0, eb && !mdir});
            chk("no_shift", {31'b0, no_shift}, {31'b0, !eb});
            chk("left_not", {31'b0, left_not}, {31'b0, !(eb && mdir)});
            chk("right_not", {31'b0, right_not}, {31'b0, !(eb && !mdir)});
            chk("old_not", {31'b0, old_not}, {31'b0, eb});
            chk("sel_onehot", {31'b0, $onehot({l_shift, r_shift, no_shift})}, 32'h1);
            chk("sh_in", sh_in, es);
            chk("result", result, es);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; returns at the negedge of its DONE cycle (or after the cycle budget)
    task automatic op(input logic [31:0] d, input logic dr, input int a, input logic r,
                      input logic [31:0] exp, input string nm, input bit poke);
        int lat = 0;
        bit seen = 1'b0;
        start = 1'b1; data_in = d; dir = dr; amt = 5'(a); rot = r;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                tick();
                if (poke && (i == 1 || i == 2)) begin
                    start = 1'b1; data_in = ~d; amt = 5'd1; dir = ~dr;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(a + 1));
        chk({nm, "_result"}, result, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sh_in", sh_in, 32'h0);
        chk("rst_no_shift", {31'b0, no_shift}, 32'h1);
        chk("rst_l_r", {30'b0, l_shift, r_shift}, 32'h0);
        chk("rst_nots", {29'b0, left_not, old_not, right_not}, 32'h5);
        chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        op(32'h0000_00F1, 1'b1, 4, 1'b0, 32'h0000_0F10, "t1_left", 1'b0);
        tick();
        op(32'hFFFF_FFFF, 1'b0, 31, 1'b0, 32'h0000_0001, "t2_right31", 1'b0);
        tick();
        op(32'h0000_0001, 1'b1, 31, 1'b0, 32'h8000_0000, "left31", 1'b0);
        tick();
        op(32'h8000_0000, 1'b1, 1, 1'b0, 32'h0000_0000, "carry_lost", 1'b0);
        tick();
        op(32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, "t3_amt0", 1'b0);
        op(32'hDEAD_BEEF, 1'b0, 1, 1'b0, 32'h6F56_DF77, "t3_b2b", 1'b0);
        tick();
        op(32'h0000_1234, 1'b1, 8, 1'b0, 32'h0012_3400, "t4_ignore_start", 1'b1);
        tick();

        // Abort an AMT=8 shift in its second cycle
        start = 1'b1; data_in = 32'hA5A5_0000; dir = 1'b1; amt = 5'd8; rot = 1'b0;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sh_in", sh_in, 32'h0);
        chk("abort_no_shift", {31'b0, no_shift}, 32'h1);
        chk("abort_l_shift", {31'b0, l_shift}, 32'h0);
        chk("abort_busy_done", {30'b0, busy, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; data_in = 32'h0000_0005; amt = 5'd2;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk("release_start_busy", {31'b0, busy}, 32'h0);
        chk("release_start_sh_in", sh_in, 32'h0);
        repeat (4) tick();

        op(32'h8000_0001, 1'b1, 1, 1'b1, ROT_EN ? 32'h0000_0003 : 32'h0000_0002, "t5_rot_left", 1'b0);
        tick();
        op(32'h8000_0001, 1'b0, 1, 1'b1, ROT_EN ? 32'hC000_0000 : 32'h4000_0000, "t5_rot_right", 1'b0);
        tick();
        op(32'h1234_5678, 1'b0, 12, 1'b1, ROT_EN ? 32'h6781_2345 : 32'h0001_2345, "rot_right12", 1'b0);
        tick();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
